// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns each single-cycle event on trig_i into a HIGH_CYCLES-wide
// pulse on dat_o followed by a GAP_CYCLES idle gap, so a slower clock can sample it.
// Events arriving during a pulse or gap are counted and replayed in order.
module pulse_stretcher #(
  parameter logic        PULSE_VALUE   = 1'b1,
  parameter int unsigned HIGH_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned PENDING_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trig_i,
  input  logic                     clr_i,
  output logic                     dat_o,
  output logic                     busy_o,
  output logic [PENDING_WIDTH-1:0] pending_o,
  output logic                     overflow_o
);

  localparam int unsigned CntMax = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0]          HighLoad = CntW'(HIGH_CYCLES - 1);
  localparam logic [CntW-1:0]          GapLoad  = CntW'(GAP_CYCLES - 1);
  localparam logic [PENDING_WIDTH-1:0] PendMax  = {PENDING_WIDTH{1'b1}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [PENDING_WIDTH-1:0] pend_q, pend_d;
  logic                     dat_q, dat_d;
  logic                     busy_q, busy_d;
  logic                     ovf_q, ovf_d;

  logic trig;
  logic enqueue;
  logic ovf_set;

  assign trig = (trig_i == PULSE_VALUE);

  // Next-state: pulse/gap sequencing, event queueing and sticky overflow.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    enqueue = 1'b0;
    ovf_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_HIGH;
          cnt_d   = HighLoad;
        end
      end
      ST_HIGH: begin
        enqueue = trig;
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          // Exit edge: a trig here either starts the next pulse directly or
          // replaces the dequeued event, so the count never moves up.
          if ((pend_q != '0) || trig) begin
            state_d = ST_HIGH;
            cnt_d   = HighLoad;
            if ((pend_q != '0) && !trig) begin
              pend_d = pend_q - 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          enqueue = trig;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase

    if (enqueue) begin
      if (pend_q == PendMax) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end

    // A new overflow takes priority over a same-cycle clear.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    dat_d  = (state_d == ST_HIGH) ? PULSE_VALUE : ~PULSE_VALUE;
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      dat_q   <= ~PULSE_VALUE;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dat_o      = dat_q;
  assign busy_o     = busy_q;
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher with default parameters. The reference model tracks
// the start cycle of the current pulse and a plain event count; outputs follow
// from how far the current cycle is past that start.
module tb_pulse_stretcher;

  localparam int H    = 4;
  localparam int G    = 4;
  localparam int QMAX = 15;

  logic       clk;
  logic       rst_n;
  logic       trig_i;
  logic       clr_i;
  logic       dat_o;
  logic       busy_o;
  logic [3:0] pending_o;
  logic       overflow_o;

  int checks;
  int failures;

  // Reference model
  int cyc;
  bit m_act;
  int m_s;
  int m_q;
  bit m_ovf;
  bit m_dat;

  pulse_stretcher #(
    .PULSE_VALUE  (1'b1),
    .HIGH_CYCLES  (H),
    .GAP_CYCLES   (G),
    .PENDING_WIDTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig_i    (trig_i),
    .clr_i     (clr_i),
    .dat_o     (dat_o),
    .busy_o    (busy_o),
    .pending_o (pending_o),
    .overflow_o(overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_act = 0;
    m_s   = 0;
    m_q   = 0;
    m_ovf = 0;
    m_dat = 0;
  endtask

  task automatic model_edge(input bit t, input bit c);
    bit set_ovf;
    set_ovf = 0;
    if (!m_act || cyc == m_s + H + G) begin
      // Free to start a pulse this cycle.
      if (m_q > 0 || t) begin
        if (m_q > 0 && !t) m_q = m_q - 1;
        m_act = 1;
        m_s   = cyc;
      end else begin
        m_act = 0;
      end
    end else if (t) begin
      if (m_q == QMAX) set_ovf = 1;
      else m_q = m_q + 1;
    end
    if (set_ovf) m_ovf = 1;
    else if (c) m_ovf = 0;
    m_dat = m_act && ((cyc - m_s) < H);
    cyc = cyc + 1;
  endtask

  function automatic logic [6:0] exp_vec();
    logic [3:0] q;
    q = 4'(m_q);
    return {m_dat, m_act, q, m_ovf};
  endfunction

  function automatic logic [6:0] act_vec();
    return {dat_o, busy_o, pending_o, overflow_o};
  endfunction

  // Drive one cycle of stimulus; outputs settle 1 time unit after the edge.
  task automatic step(input bit t, input bit c);
    trig_i = t;
    clr_i  = c;
    @(posedge clk);
    if (rst_n) model_edge(t, c);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step(i[0], 1'b0);
      checks++;
      if (act_vec() !== 7'b0) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got %b want %b", i, act_vec(), 7'b0);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_release cycle %0d: got %b want %b", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    int high_n;
    int busy_n;
    high_n = 0;
    busy_n = 0;
    for (int i = 0; i < 12; i++) begin
      step(i == 0, 1'b0);
      high_n += int'(dat_o);
      busy_n += int'(busy_o);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single cycle %0d: got %b want %b", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (high_n != H || busy_n != H + G) begin
      failures++;
      $display("FAIL single_width: high %0d busy %0d want %0d %0d", high_n, busy_n, H, H + G);
    end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 30; i++) begin
      step(i < 3, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL burst cycle %0d: got %b want %b", i, act_vec(), exp_vec());
      end
      if (i == 1 || i == 2) begin
        checks++;
        if (pending_o !== 4'(i)) begin
          failures++;
          $display("FAIL burst_pending cycle %0d: got %0d want %0d", i, pending_o, i);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    // Pulse at edge 0, queue one at edge 1, trig again on exit edge 8.
    for (int i = 0; i < 30; i++) begin
      step(i == 0 || i == 1 || i == 8, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL simul cycle %0d: got %b want %b", i, act_vec(), exp_vec());
      end
      if (i == 8) begin
        checks++;
        if (pending_o !== 4'd1 || dat_o !== 1'b1) begin
          failures++;
          $display("FAIL simul_exit: got pend %0d dat %b want 1 1", pending_o, dat_o);
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (busy_o === 1'b1 && n < 400) begin
      step(1'b0, 1'b0);
      n++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL %s_drain cycle %0d: got %b want %b", name, n, act_vec(), exp_vec());
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout: busy %b want 0", name, busy_o);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL ovf_fill cycle %0d: got %b want %b", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (overflow_o !== 1'b1 || pending_o !== 4'd15) begin
      failures++;
      $display("FAIL ovf_set: got ovf %b pend %0d want 1 15", overflow_o, pending_o);
    end
    drain("ovf");
    step(1'b0, 1'b1);
    checks++;
    if (overflow_o !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got %b want 0", overflow_o);
    end
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL ovf_refill cycle %0d: got %b want %b", i, act_vec(), exp_vec());
      end
    end
    // Edge 18 of the run is not a gap-exit edge, so this trig overflows.
    step(1'b1, 1'b1);
    checks++;
    if (overflow_o !== 1'b1 || act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL ovf_set_wins: got %b want %b", act_vec(), exp_vec());
    end
    drain("ovf2");
    step(1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cycle %0d: got %b want %b", i, act_vec(), exp_vec());
      end
    end
    drain("random");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    checks++;
    if (pending_o !== 4'd2 || dat_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup: got pend %0d dat %b want 2 1", pending_o, dat_o);
    end
    trig_i = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act_vec() !== 7'b0) begin
      failures++;
      $display("FAIL mid_async: got %b want %b", act_vec(), 7'b0);
    end
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL mid_after cycle %0d: got %b want %b", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    trig_i   = 1'b0;
    clr_i    = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_burst();
    test_simultaneous();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
